// File: rtl/barrel_shift_pkg.sv
// Shared types and constants for the pipelined barrel shifter.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package barrel_shift_pkg;

    // Operation encoding carried on in_op and through every rank.
    localparam logic [1:0] OP_SLL = 2'b00;  // logical left, zero fill
    localparam logic [1:0] OP_SRL = 2'b01;  // logical right, zero fill
    localparam logic [1:0] OP_SRA = 2'b10;  // arithmetic right, sign fill
    localparam logic [1:0] OP_ROR = 2'b11;  // rotate right

    typedef enum logic [1:0] {
        SHIFT_SLL = OP_SLL,
        SHIFT_SRL = OP_SRL,
        SHIFT_SRA = OP_SRA,
        SHIFT_ROR = OP_ROR
    } shift_op_e;

    // Number of register ranks for a given number of mux levels.
    function automatic int num_ranks(input int levels, input int reg_every);
        return (levels + reg_every - 1) / reg_every;
    endfunction

endpackage

// File: rtl/barrel_shift_level.sv
// One mux level of the barrel shifter: shift/rotate by a fixed AMT when en=1, else pass.
// Latency: combinational.
// Backpressure: none (pure datapath).
//
// Ports: data (operand), en (this level's shamt bit), op (shift_op_e), result.
module barrel_shift_level
    import barrel_shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT   = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    input  shift_op_e        op,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = data;
        if (en) begin
            case (op)
                SHIFT_SLL: result = data << AMT;
                SHIFT_SRL: result = data >> AMT;
                // Arithmetic shifts compose, so the MSB seen here is always the
                // original operand's sign bit.
                SHIFT_SRA: result = WIDTH'($signed(data) >>> AMT);
                SHIFT_ROR: result = {data[AMT-1:0], data[WIDTH-1:AMT]};
                default:   result = data;
            endcase
        end
    end

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR) with a sideband tag carried alongside.
// Latency: R = ceil(log2(WIDTH)/REG_EVERY) cycles from acceptance, one op per cycle.
// Backpressure: whole pipe stalls while out_valid && !out_ready; in_ready = out_ready || !out_valid.
//
// Ports: clk, rst (async active-high); in_valid/in_ready/in_data/in_shamt/in_op/in_tag;
//        out_valid/out_ready/out_data/out_tag; out_zero only when BARREL_SHIFT_ZERO_FLAG_EN
//        is defined (out_zero = (out_data == 0), registered with the last rank).
module barrel_shift_pipe
    import barrel_shift_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int REG_EVERY = 2,
    parameter int TAG_W     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_shamt,
    input  logic [1:0]               in_op,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [TAG_W-1:0]         out_tag
`ifdef BARREL_SHIFT_ZERO_FLAG_EN
    ,
    output logic                     out_zero
`endif
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int RANKS  = num_ranks(LEVELS, REG_EVERY);

    // Single advance enable: every rank moves together or holds together.
    logic adv;

    // Rank boundaries: index 0 is the input port, index r+1 is rank r's register.
    // Shamt/op are only needed ahead of the last rank.
    logic              bnd_vld   [RANKS+1];
    logic [WIDTH-1:0]  bnd_data  [RANKS+1];
    logic [TAG_W-1:0]  bnd_tag   [RANKS+1];
    logic [LEVELS-1:0] bnd_shamt [RANKS];
    shift_op_e         bnd_op    [RANKS];

    logic [WIDTH-1:0]  lvl_out   [LEVELS];

    assign adv      = out_ready || !out_valid;
    assign in_ready = adv;

    assign bnd_vld[0]   = in_valid;
    assign bnd_data[0]  = in_data;
    assign bnd_tag[0]   = in_tag;
    assign bnd_shamt[0] = in_shamt;
    assign bnd_op[0]    = shift_op_e'(in_op);

    assign out_valid = bnd_vld[RANKS];
    assign out_data  = bnd_data[RANKS];
    assign out_tag   = bnd_tag[RANKS];

    // Mux levels: level k belongs to segment k/REG_EVERY; the first level of a
    // segment reads the preceding rank, the rest chain combinationally.
    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int SEG = k / REG_EVERY;
        logic [WIDTH-1:0] lvl_in;

        if (k % REG_EVERY == 0) begin : g_head
            assign lvl_in = bnd_data[SEG];
        end else begin : g_chain
            assign lvl_in = lvl_out[k-1];
        end

        barrel_shift_level #(
            .WIDTH (WIDTH),
            .AMT   (1 << k)
        ) u_level (
            .data   (lvl_in),
            .en     (bnd_shamt[SEG][k]),
            .op     (bnd_op[SEG]),
            .result (lvl_out[k])
        );
    end

    // Register ranks: rank r captures the output of the last level of segment r.
    for (genvar r = 0; r < RANKS; r++) begin : g_rank
        localparam int LAST_LVL = ((r + 1) * REG_EVERY > LEVELS) ? LEVELS - 1
                                                                 : (r + 1) * REG_EVERY - 1;
        logic             vld_q;
        logic [WIDTH-1:0] data_q;
        logic [TAG_W-1:0] tag_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q  <= 1'b0;
                data_q <= '0;
                tag_q  <= '0;
            end else if (adv) begin
                vld_q  <= bnd_vld[r];
                data_q <= lvl_out[LAST_LVL];
                tag_q  <= bnd_tag[r];
            end
        end

        assign bnd_vld[r+1]  = vld_q;
        assign bnd_data[r+1] = data_q;
        assign bnd_tag[r+1]  = tag_q;

        // Control for the remaining levels; the full shamt is kept, downstream
        // segments only consult the bits of their own levels.
        if (r < RANKS - 1) begin : g_ctl
            logic [LEVELS-1:0] shamt_q;
            shift_op_e         op_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    shamt_q <= '0;
                    op_q    <= SHIFT_SLL;
                end else if (adv) begin
                    shamt_q <= bnd_shamt[r];
                    op_q    <= bnd_op[r];
                end
            end

            assign bnd_shamt[r+1] = shamt_q;
            assign bnd_op[r+1]    = op_q;
        end
    end

`ifdef BARREL_SHIFT_ZERO_FLAG_EN
    // Computed from the final level so it lands in the same cycle as out_data.
    logic zero_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q <= 1'b0;
        end else if (adv) begin
            zero_q <= (lvl_out[LEVELS-1] == '0);
        end
    end

    assign out_zero = zero_q;
`endif

endmodule

// File: doc/barrel_shift_pipe.md
BARREL_SHIFT_PIPE -- requirements
Module: barrel_shift_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width; power of two, 4..128.
REQ-002 SHALL have parameter REG_EVERY, default 2, mux levels per pipeline register rank, 1..log2(WIDTH).
REQ-003 SHALL have parameter TAG_W, default 4, width of the sideband tag carried with each operation.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  operation offered.
REQ-007 in_ready  output  1  operation accepted when in_valid && in_ready.
REQ-008 in_data  input  WIDTH  operand.
REQ-009 in_shamt  input  log2(WIDTH)  shift amount.
REQ-010 in_op  input  2  operation (shift_op_e).
REQ-011 in_tag  input  TAG_W  sideband, returned unchanged.
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 out_data  output  WIDTH  result.
REQ-015 out_tag  output  TAG_W  tag of the result.

Function
REQ-016 Ops: 00 SLL (zero fill), 01 SRL (zero fill), 10 SRA (sign fill from in_data[WIDTH-1]), 11 ROR (rotate right).
REQ-017 Mux level k (k=0..log2(WIDTH)-1) SHALL shift/rotate by exactly 2^k when in_shamt[k]=1, else pass through.
REQ-018 Register ranks SHALL follow every REG_EVERY levels, the last rank after the final level; R = ceil(log2(WIDTH)/REG_EVERY) ranks.
REQ-019 Latency SHALL be exactly R cycles from acceptance to out_valid with no back-pressure (WIDTH=32, REG_EVERY=2: R=3).
REQ-020 Each rank SHALL carry a valid bit, partial data, remaining shamt bits, op and tag.
REQ-021 Pipeline advance enable SHALL be adv = out_ready || !out_valid; all ranks hold when adv=0.
REQ-022 in_ready SHALL equal adv (combinational from out_ready and out_valid only).
REQ-023 Bubbles SHALL propagate as invalid ranks; out_data/out_tag are don't-care when out_valid=0.
REQ-024 in_shamt=0 SHALL return in_data unchanged for every op.
REQ-025 Throughput SHALL be one op per cycle while out_ready=1.
REQ-026 Results SHALL leave in acceptance order; no op dropped or duplicated under any out_ready pattern.
REQ-027 While out_valid=1 and out_ready=0, out_data and out_tag SHALL remain stable.

Reset
REQ-028 rst=1 SHALL clear all rank valid bits immediately; out_valid=0, out_data=0, out_tag=0.
REQ-029 In-flight ops SHALL be discarded by reset mid-operation; first result after release requires a new acceptance.
REQ-030 in_ready SHALL be 1 during and after reset (out_valid=0).

Configuration
REQ-031 With BARREL_SHIFT_ZERO_FLAG_EN defined: output out_zero (1 bit) SHALL equal (out_data == 0), registered with the last rank, reset 0.
REQ-032 Without BARREL_SHIFT_ZERO_FLAG_EN: out_zero port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-033 Package barrel_shift_pkg SHALL hold typedef enum shift_op_e (SLL, SRL, SRA, ROR) and the encoding constants.
REQ-034 Sub-module barrel_shift_level SHALL implement one mux level (parameters WIDTH, AMT=2^k; inputs data, en, op; output data); top instantiates log2(WIDTH) copies via generate.

Verification (WIDTH=32, REG_EVERY=2, TAG_W=4)
REQ-035 SLL 0x0000_0001 shamt 31 tag 5, out_ready=1 -> cycle 3: out_data 0x8000_0000, out_tag 5.
REQ-036 SRA 0x8000_0000 shamt 4 -> 0xF800_0000; SRL same -> 0x0800_0000; ROR 0x0000_00F1 shamt 4 -> 0x1000_000F.
REQ-037 Back-to-back 8 ops, out_ready low cycles 4-6 -> in_ready low those cycles, out_data stable, all 8 results in order, none lost.
REQ-038 Accept 2 ops, assert rst in cycle 2 -> out_valid stays 0; after release, no stale result appears.
REQ-039 shamt 0 for all four ops on 0xDEAD_BEEF -> 0xDEAD_BEEF each; with BARREL_SHIFT_ZERO_FLAG_EN, SRL 0x0000_0001 shamt 1 -> out_zero=1.
REQ-040 Random 10k ops, random out_ready, REG_EVERY in {1,2,5} -> match reference model, latency R when unstalled.
